fifo_rd_pack: RTL
=================

# fifo_rd_pack

Read-side consumer for the dual-clock FIFO. Lives entirely in the read clock domain and drains the FIFO's rdata/rempty/rinc port. It packs RATIO consecutive DSIZE-bit words into one wide beat and presents that beat on a valid/ready stream through a 2-entry output buffer. A flush request emits a partially filled beat with a valid-lane count.

## Interface
- DSIZE, 8: FIFO word width in bits.
- RATIO, 4: FIFO words per output beat; legal values 2..16.
- CW, $clog2(RATIO)+1: width of lane count (derived; not overridden).
- rclk  in  1  read-domain clock; all logic on rising edge.
- rrst_n  in  1  reset. One clock; reset is synchronous and active-low.
- rdata  in  DSIZE  FIFO read data; valid in the same cycle whenever rempty=0.
- rempty  in  1  FIFO empty flag.
- rinc  out  1  FIFO read strobe; the word on rdata is consumed at the rclk edge where rinc=1.
- flush  in  1  single-cycle pulse: emit the partial beat currently held.
- m_data  out  DSIZE*RATIO  output beat; lane i = bits [i*DSIZE +: DSIZE]; lane 0 = oldest word.
- m_cnt  out  CW  number of valid lanes in m_data (RATIO for full beats, 1..RATIO-1 for flushed beats).
- m_valid  out  1  output beat valid.
- m_ready  in  1  downstream accept.
- busy  out  1  high when idx!=0, flush_pend=1 or m_valid=1.

## Operation
- State: accumulator acc[DSIZE*RATIO], lane index idx (0..RATIO-1), flush_pend, output buffer of 2 entries {data, cnt} with buf_cnt (0..2).
- Control FSM (encoded by idx/flush_pend):
  - ACC: accepts FIFO words.
  - FLUSH: flush_pend=1, waiting for buffer space.
  - Transitions: ACC -> FLUSH on flush=1. FLUSH -> ACC when the partial beat is pushed, or immediately if idx=0.
- rinc is combinational:
  - rinc = rrst_n & !rempty & !flush_pend & (idx != RATIO-1 | buf_cnt < 2).
  - Uses registered state only; there is no path from m_ready to rinc.
- Word read (rinc=1):
  - acc lane idx <= rdata.
  - If idx = RATIO-1: push {acc with final lane, cnt=RATIO} into the buffer and set idx <= 0.
  - Otherwise idx <= idx+1.
- Flush:
  - flush=1 sets flush_pend at that edge.
  - A word read at that same edge still lands in acc. If it completes a beat, idx becomes 0 and the flush emits nothing.
  - While flush_pend=1:
    - if idx=0, clear flush_pend.
    - else if buf_cnt < 2, push {acc lanes 0..idx-1, unused lanes zero, cnt=idx}, then set idx <= 0, clear flush_pend, and zero acc.
  - A flush pulse while flush_pend=1 is absorbed; there is no second emit.
- acc is zeroed after every push, so unused lanes of a flushed beat are always 0.
- Output:
  - m_valid = (buf_cnt != 0).
  - m_data/m_cnt come from the head entry and are driven from registers.
  - Pop on m_valid & m_ready.
  - Push and pop in the same cycle are legal; buf_cnt is unchanged and order is preserved.
  - m_data/m_cnt hold stable while m_valid=1 and m_ready=0.
- Overflow is impossible by construction: a push never occurs when buf_cnt=2.

## Timing
- Reset (rrst_n=0 at an edge): idx=0, flush_pend=0, buf_cnt=0, acc=0.
- Outputs after reset: m_valid=0, m_data=0, m_cnt=0, busy=0; rinc=0 while rrst_n=0.
- Reset mid-operation discards the partial beat and buffered beats. FIFO words already consumed are lost; no flush is generated.
- Latency: the edge that reads the RATIO-th word is followed by m_valid=1 in the next cycle.
- Flushed beat: m_valid=1 two cycles after the flush edge if buf_cnt<2.
- Throughput: one FIFO word per cycle sustained while m_ready=1.
- Stall behaviour:
  - With m_ready=0, the block reads 2*RATIO + (RATIO-1) words and then holds rinc=0 at idx=RATIO-1.
  - rinc returns 1 the cycle after the first pop.
- rempty toggling mid-beat only pauses idx; partial beats are held indefinitely until more data or a flush arrives.

## Test plan
- RATIO=4, DSIZE=8, FIFO preloaded 0x11,0x22,0x33,0x44,0x55,0x66,0x77,0x88, m_ready=1 -> two beats: m_data=0x44332211 then 0x88776655, both m_cnt=4; rinc high 8 consecutive cycles.
- Partial flush: push 0xA1,0xB2,0xC3, then flush pulse -> one beat m_data=0x00C3B2A1, m_cnt=3; idx back to 0, busy=0 after the pop.
- Backpressure: m_ready=0, FIFO holds 16 words 0x00..0x0F -> rinc stops after 11 reads, m_data=0x03020100 held stable. Releasing m_ready drains beats 0x03020100, 0x07060504, 0x0B0A0908, 0x0F0E0D0C in order with no loss.
- Flush coincident with 4th-word read: flush on the same edge as reading 0x44 -> exactly one beat 0x44332211 with m_cnt=4, no empty beat. Flush with idx=0 -> no beat.
- Flush with buffer full: m_ready=0, buf_cnt=2, idx=2, flush -> rinc=0 while pending. Partial beat with m_cnt=2 is pushed the cycle after the first pop and emerges third.
- Reset mid-beat: after 2 words, rrst_n=0 for one edge -> m_valid=0, m_cnt=0, busy=0. Next 4 words form a clean beat with no residue from the old lanes.

Source files
------------

// File: rtl/fifo_rd_pack_if.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pack_if
// Brief    : Packed-beat valid/ready stream carried out of fifo_rd_pack.
// Revision : 1.0
// ============================================================================
interface fifo_rd_pack_if #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4,
  parameter int CW    = $clog2(RATIO) + 1
) ();

  logic [DSIZE*RATIO-1:0] m_data;
  logic [CW-1:0]          m_cnt;
  logic                   m_valid;
  logic                   m_ready;

  modport master (
    output m_data,
    output m_cnt,
    output m_valid,
    input  m_ready
  );

  modport slave (
    input  m_data,
    input  m_cnt,
    input  m_valid,
    output m_ready
  );

endinterface
`default_nettype wire

// File: rtl/fifo_rd_pack.sv
`default_nettype none
// ============================================================================
// Module   : fifo_rd_pack
// Brief    : Drains a FIFO read port, packs RATIO words per beat, 2-deep output.
// Revision : 1.0
// ============================================================================
module fifo_rd_pack #(
  parameter int DSIZE = 8,
  parameter int RATIO = 4,
  parameter int CW    = $clog2(RATIO) + 1
) (
  input  wire logic             rclk,
  input  wire logic             rrst_n,
  input  wire logic [DSIZE-1:0] rdata,
  input  wire logic             rempty,
  output logic                  rinc,
  input  wire logic             flush,
  output logic                  busy,
  fifo_rd_pack_if.master        m
);

  localparam int IW = $clog2(RATIO);
  localparam int WW = DSIZE * RATIO;

  localparam logic [IW-1:0] c_last_idx = IW'(RATIO - 1);
  localparam logic [1:0]    c_buf_full = 2'd2;
  localparam logic [0:0]    c_st_acc   = 1'b0;
  localparam logic [0:0]    c_st_flush = 1'b1;

  logic [WW-1:0] r_acc;
  logic [IW-1:0] r_idx;
  logic [0:0]    r_state;
  logic [1:0]    r_buf_cnt;
  logic [WW-1:0] r_buf_data0;
  logic [WW-1:0] r_buf_data1;
  logic [CW-1:0] r_buf_lanes0;
  logic [CW-1:0] r_buf_lanes1;

  logic          w_pend;
  logic          w_room;
  logic          w_valid;
  logic          w_rinc;
  logic          w_last;
  logic          w_full_push;
  logic          w_flush_push;
  logic          w_push;
  logic          w_pop;
  logic          w_slot;
  logic [WW-1:0] w_acc_wr;
  logic [WW-1:0] w_push_data;
  logic [CW-1:0] w_push_lanes;
  logic [WW-1:0] w_nxt_data0;
  logic [WW-1:0] w_nxt_data1;
  logic [CW-1:0] w_nxt_lanes0;
  logic [CW-1:0] w_nxt_lanes1;
  logic [1:0]    w_nxt_cnt;

  assign w_pend  = (r_state == c_st_flush);
  assign w_room  = (r_buf_cnt < c_buf_full);
  assign w_valid = (r_buf_cnt != 2'd0);
  assign w_last  = (r_idx == c_last_idx);

  // Only the beat-completing read needs buffer space; m_ready never reaches rinc.
  assign w_rinc = rrst_n & ~rempty & ~w_pend & (~w_last | w_room);
  assign rinc   = w_rinc;

  assign w_full_push  = w_rinc & w_last;
  assign w_flush_push = w_pend & (r_idx != '0) & w_room;
  assign w_push       = w_full_push | w_flush_push;
  assign w_pop        = w_valid & m.m_ready;

  generate
    for (genvar i = 0; i < RATIO; i++) begin : g_lane
      assign w_acc_wr[i*DSIZE +: DSIZE] =
        (w_rinc && (r_idx == IW'(i))) ? rdata : r_acc[i*DSIZE +: DSIZE];
    end
  endgenerate

  // Lanes at and above idx are always zero in r_acc, so a flush beat is r_acc as-is.
  assign w_push_data  = w_full_push ? w_acc_wr : r_acc;
  assign w_push_lanes = w_full_push ? CW'(RATIO) : {1'b0, r_idx};

  // Pushes only happen with room, so the free slot is index 0 or 1.
  assign w_slot = (r_buf_cnt == 2'd1) & ~w_pop;

  always_comb begin
    w_nxt_data0  = r_buf_data0;
    w_nxt_data1  = r_buf_data1;
    w_nxt_lanes0 = r_buf_lanes0;
    w_nxt_lanes1 = r_buf_lanes1;
    if (w_pop) begin
      w_nxt_data0  = r_buf_data1;
      w_nxt_lanes0 = r_buf_lanes1;
      w_nxt_data1  = '0;
      w_nxt_lanes1 = '0;
    end
    if (w_push) begin
      if (w_slot) begin
        w_nxt_data1  = w_push_data;
        w_nxt_lanes1 = w_push_lanes;
      end else begin
        w_nxt_data0  = w_push_data;
        w_nxt_lanes0 = w_push_lanes;
      end
    end
    w_nxt_cnt = r_buf_cnt + {1'b0, w_push} - {1'b0, w_pop};
  end

  always_ff @(posedge rclk) begin
    if (!rrst_n) begin
      r_acc        <= '0;
      r_idx        <= '0;
      r_state      <= c_st_acc;
      r_buf_cnt    <= 2'd0;
      r_buf_data0  <= '0;
      r_buf_data1  <= '0;
      r_buf_lanes0 <= '0;
      r_buf_lanes1 <= '0;
    end else begin
      if (w_push) begin
        r_idx <= '0;
        r_acc <= '0;
      end else if (w_rinc) begin
        r_idx <= r_idx + 1'b1;
        r_acc <= w_acc_wr;
      end

      // A flush pulse arriving while one is already pending is absorbed.
      case (r_state)
        c_st_acc:   if (flush) r_state <= c_st_flush;
        c_st_flush: if ((r_idx == '0) || w_flush_push) r_state <= c_st_acc;
        default:    r_state <= c_st_acc;
      endcase

      r_buf_cnt    <= w_nxt_cnt;
      r_buf_data0  <= w_nxt_data0;
      r_buf_data1  <= w_nxt_data1;
      r_buf_lanes0 <= w_nxt_lanes0;
      r_buf_lanes1 <= w_nxt_lanes1;
    end
  end

  assign m.m_data  = r_buf_data0;
  assign m.m_cnt   = r_buf_lanes0;
  assign m.m_valid = w_valid;
  assign busy      = (r_idx != '0) | w_pend | w_valid;

endmodule
`default_nettype wire
